count_prog: RTL
===============

# count_prog

Programmable up/down modulo counter, next generation of the spectrum analyzer's fixed-step counter. The width, step, terminal value, wrap/saturate mode and clock-enable prescale are set by parameters or runtime inputs. It also supports synchronous load and a registered terminal-count pulse for cascading. It drives the sample and bin address generators and the display sweep timers.

## Interface
Parameters:
- W, 8, counter width in bits; output range 0..2^W-1.
- PRE, 1, prescale ratio; one count event per PRE enabled cycles (PRE ≥ 1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- RE  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable into the prescaler.
- dir  in  1  0 = count up, 1 = count down.
- sat  in  1  0 = wrap at bounds, 1 = saturate at bounds.
- LD  in  1  synchronous load of din.
- din  in  W  load value.
- step  in  W  increment magnitude per count event.
- top  in  W  terminal value; count range is 0..top.
- out  out  W  counter value (registered).
- tc  out  1  terminal-count pulse (registered).

## Operation
- Priority per edge: RE > LD > count event > hold.
- RE (async): out=0, tc=0, prescaler=0. Held while RE high.
- LD: out=din (not clamped to top), prescaler=0, tc=0. CE is ignored that cycle.
- Prescaler: a counter pre_cnt runs 0..PRE-1 and advances only when CE=1.
  - A count event fires on an enabled cycle with pre_cnt==PRE-1; pre_cnt then returns to 0.
  - With PRE=1, every CE=1 cycle is an event. The prescaler register is omitted in that case.
- Effective step: stp = min(step, top). All sums are computed in W+1 bits; no intermediate truncation.
- Out-of-range value (out > top, e.g. after top lowered or LD): on the next event the result is 0 for up and top for down in wrap mode, and top in saturate mode. tc=1 in both modes.
- Up (dir=0), with s = out + stp:
  - s ≤ top: out=s, tc=0.
  - s > top, wrap: out = s − (top+1), tc=1.
  - s > top, saturate: out=top, tc=1.
- Down (dir=1):
  - out ≥ stp: out = out − stp, tc=0.
  - out < stp, wrap: out = out + (top+1) − stp, tc=1.
  - out < stp, saturate: out=0, tc=1.
- In saturate mode, tc repeats on every further event that pushes against the bound.
- stp=0 (step=0 or top=0): out unchanged, tc=0. Exception: an out-of-range value is still corrected and sets tc=1.
- dir, sat, step and top are sampled on the event edge only. Changing them has no other effect.
- Non-event cycles: out holds, tc=0.

## Timing
- out updates on the event edge; the new value is visible the following cycle. Latency is 1 cycle from the event-qualifying CE.
- tc is high for exactly the one cycle following an event that wrapped, saturated or corrected. It is never high for two cycles from one event.
- With PRE>1, the first event after reset or LD needs PRE cycles with CE=1. CE=0 cycles stall the prescaler without losing progress.
- RE asserted mid-count clears out, tc and prescaler immediately, without waiting for clk. The first event after RE deasserts follows the normal prescaler rule.
- LD and an event on the same edge: LD wins, no count, tc=0.
- Cascading: the tc of stage n drives the CE of stage n+1. Stage n+1 updates one cycle after stage n wraps.

## Test plan
- W=4, PRE=1, top=15, step=1, up, wrap, CE=1 for 17 cycles from reset: out 0,1,…,15,0. tc high only in the cycle after the 15→0 transition.
- W=4, top=9, step=3, up, wrap, from 0: out 3,6,9,2,5,8,1. tc high after 9→2 and 8→1. With dir=1 from 1: out 8, tc=1.
- Saturate mode, top=12, step=5, up from 0: out 5,10,12,12. tc=1 after the 3rd and 4th events. Down from 3 with step=5: out 0, tc=1.
- PRE=4, CE toggling 1,0,1,1,0,1 from reset: exactly one event, on the 4th CE=1 cycle; out=step afterward. LD on the same edge as an event: out=din, tc=0, prescaler restarts.
- LD din=14 then top=9, up, step=1, wrap: next event gives out=0, tc=1. Step=0 with out=5: out holds 5, tc stays 0.
- RE pulse asynchronous to clk while out=7, mid-prescale (PRE=3, pre_cnt=2): out=0, tc=0 immediately. After release, the next event needs 3 CE=1 cycles.

Source files
------------

// File: rtl/count_prog.sv
// Programmable up/down modulo counter with optional prescaler, wrap or saturate
// at the bounds, synchronous load and a registered terminal-count pulse.
module count_prog #(
    parameter int W   = 8,
    parameter int PRE = 1
) (
    input  logic         clk,
    input  logic         RE,
    input  logic         CE,
    input  logic         dir,
    input  logic         sat,
    input  logic         LD,
    input  logic [W-1:0] din,
    input  logic [W-1:0] step,
    input  logic [W-1:0] top,
    output logic [W-1:0] out,
    output logic         tc
);

    localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRE - 1);

    logic         ev;
    logic [W-1:0] stp;
    logic [W:0]   nxt;

    // Next {tc, value} for one count event; all arithmetic is W+1 bits wide.
    function automatic logic [W:0] count_next(
        input logic [W-1:0] cur,
        input logic [W-1:0] s_in,
        input logic [W-1:0] t_in,
        input logic         down,
        input logic         satm
    );
        logic [W:0]   c, s, t, t1, sum;
        logic [W-1:0] val;
        logic         flag;
        c    = {1'b0, cur};
        s    = {1'b0, s_in};
        t    = {1'b0, t_in};
        t1   = t + {{W{1'b0}}, 1'b1};
        sum  = c + s;
        val  = cur;
        flag = 1'b0;
        if (c > t) begin
            // Out-of-range value (after LD or a lowered top) is pulled back in.
            val  = (satm || down) ? t_in : '0;
            flag = 1'b1;
        end else if (s == '0) begin
            val  = cur;
            flag = 1'b0;
        end else if (!down) begin
            if (sum <= t) begin
                val = sum[W-1:0];
            end else begin
                sum  = sum - t1;
                val  = satm ? t_in : sum[W-1:0];
                flag = 1'b1;
            end
        end else begin
            if (c >= s) begin
                sum = c - s;
                val = sum[W-1:0];
            end else begin
                sum  = c + t1 - s;
                val  = satm ? '0 : sum[W-1:0];
                flag = 1'b1;
            end
        end
        return {flag, val};
    endfunction

    assign stp = (step > top) ? top : step;
    assign nxt = count_next(out, stp, top, dir, sat);

    generate
        if (PRE > 1) begin : g_pre
            logic [PW-1:0] pre_cnt;

            always_ff @(posedge clk or posedge RE) begin
                if (RE) begin
                    pre_cnt <= '0;
                end else if (LD) begin
                    pre_cnt <= '0;
                end else if (CE) begin
                    pre_cnt <= (pre_cnt == PMAX) ? '0 : pre_cnt + PW'(1);
                end
            end

            assign ev = CE && (pre_cnt == PMAX);
        end else begin : g_nopre
            assign ev = CE;
        end
    endgenerate

    always_ff @(posedge clk or posedge RE) begin
        if (RE) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (LD) begin
            out <= din;
            tc  <= 1'b0;
        end else if (ev) begin
            out <= nxt[W-1:0];
            tc  <= nxt[W];
        end else begin
            tc  <= 1'b0;
        end
    end

endmodule
